hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard and memory-wait controller for the 5-stage ARM core. It consumes the stage-tagged control bits that the pipelined controller produces (RegWriteM/W, MemtoRegE, PCSrcD/E/M/W, BranchTakenE) and the register addresses from the datapath. It drives the ForwardAE/BE muxes, the stall/flush enables of every pipeline register (including the controller's FlushE), and a multi-cycle data-memory wait FSM with timeout. Saturating stall/flush event counters are exposed for debug.

## Interface
- MEM_TIMEOUT, 16: max consecutive wait cycles before error (≥2)
- CNT_W, 16: width of performance counters
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears FSM, timeout counter, MemErr, perf counters
- Ra1D, Ra2D  in  4  source regs in Decode
- Ra1E, Ra2E  in  4  source regs in Execute
- WA3E, WA3M, WA3W  in  4  destination reg in E/M/W
- RegWriteM, RegWriteW  in  1  qualified register write in M/W
- MemtoRegE  in  1  load in Execute
- PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1  PC write in each stage
- BranchTakenE  in  1  taken branch resolved in Execute
- MemReqM  in  1  data-memory access in Memory stage (load or store)
- MemReadyM  in  1  data memory completes access this cycle
- ForwardAE, ForwardBE  out  2  00 regfile, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  clear pipeline register (bubble)
- MemErr  out  1  sticky memory timeout
- StallCycles, FlushCycles  out  CNT_W  saturating event counters

## Operation
- Forwarding (per operand X∈{1,2}, Y∈{A,B}): ForwardYE=10 if RegWriteM & RaXE==WA3M & RaXE!=15; else 01 if RegWriteW & RaXE==WA3W & RaXE!=15; else 00. M has priority over W.
- LDRstall = MemtoRegE & (Ra1D==WA3E | Ra2D==WA3E).
- PCWrPend = PCSrcD | PCSrcE | PCSrcM.
- MemStall = (state==IDLE & MemReqM & ~MemReadyM) | state==WAIT | state==ERR.
- Without MemStall: StallF = LDRstall | PCWrPend; StallD = LDRstall; StallE = StallM = 0; FlushD = PCWrPend | PCSrcW | BranchTakenE; FlushE = LDRstall | BranchTakenE; FlushW = 0.
- With MemStall: StallF = StallD = StallE = StallM = 1; FlushD = FlushE = 0 (freeze beats flush); FlushW = 1 (bubble into Writeback so the M instruction does not write twice).
- FSM states IDLE, WAIT, ERR:
  - IDLE→WAIT when MemReqM & ~MemReadyM; wait counter loads 1.
  - WAIT→IDLE when MemReadyM (stall still asserted that cycle; the pipeline advances on the following edge).
  - WAIT: if ~MemReadyM, counter increments; when counter==MEM_TIMEOUT-1 and ~MemReadyM → ERR.
  - ERR: MemErr=1, full stall held, exit only by reset. MemReadyM ignored.
  - IDLE with MemReqM & MemReadyM: no stall, stays IDLE.
- Counters: StallCycles +1 each cycle StallF=1; FlushCycles +1 each cycle FlushE=1; both saturate at 2^CNT_W−1, never wrap.

## Timing
- Forwarding, stall, flush outputs are combinational from inputs and current state; no added latency.
- MemErr, state, counters registered; MemErr rises the cycle after the transition edge into ERR.
- Reset values: state=IDLE, wait counter=0, MemErr=0, StallCycles=FlushCycles=0. Combinational outputs follow the IDLE equations during reset.
- Reset mid-WAIT or in ERR: immediate return to IDLE, MemErr cleared asynchronously.
- LDRstall and BranchTakenE in the same cycle: FlushE=1, StallD=1, FlushD=1.
- LDRstall plus MemStall: MemStall equations win.
- A wait of exactly MEM_TIMEOUT−1 cycles with MemReadyM arriving on the last cycle completes without error.

## Test plan
- Forward priority: RegWriteM=RegWriteW=1, WA3M=WA3W=Ra1E=3 → ForwardAE=10; RegWriteM=0 → 01; Ra1E=15 → 00.
- Load-use: MemtoRegE=1, WA3E=5, Ra2D=5 → StallF=StallD=FlushE=1 for one cycle, FlushD=0, StallCycles +1.
- Branch: BranchTakenE=1 → FlushD=FlushE=1, StallF=0; PCSrcD=1 for 3 cycles → StallF=FlushD=1 each cycle, then PCSrcW=1 → FlushD=1 only.
- Memory wait: MemReqM=1, MemReadyM low 3 cycles then high → StallF/D/E/M=1 and FlushW=1 for 4 cycles, FlushE forced 0 even with BranchTakenE=1, back to IDLE, MemErr=0.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 → ERR entered, MemErr=1 next cycle and stall persists; assert reset mid-ERR → MemErr=0, state IDLE, counters 0.
- Saturation: CNT_W=4, hold LDRstall 20 cycles → StallCycles stops at 15.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard, forwarding and data-memory wait control for the 5-stage ARM pipeline.
// Drives forward muxes, stall/flush enables, a wait/timeout FSM and debug counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       Ra1D,
  input  logic [3:0]       Ra2D,
  input  logic [3:0]       Ra1E,
  input  logic [3:0]       Ra2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCycles
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_t;

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WLAST = WCW'(MEM_TIMEOUT - 1);

  state_t         state;
  state_t         nextState;
  logic [WCW-1:0] waitCnt;
  logic [WCW-1:0] waitCntNext;

  logic ldrStall;
  logic pcWrPend;
  logic memStall;

  // R15 reads the PC, never a forwarded result
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && Ra1E == WA3M && Ra1E != 4'd15)
      ForwardAE = 2'b10;
    else if (RegWriteW && Ra1E == WA3W && Ra1E != 4'd15)
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && Ra2E == WA3M && Ra2E != 4'd15)
      ForwardBE = 2'b10;
    else if (RegWriteW && Ra2E == WA3W && Ra2E != 4'd15)
      ForwardBE = 2'b01;
  end

  assign ldrStall = MemtoRegE
                  & ((Ra1D == WA3E) | (Ra2D == WA3E));
  assign pcWrPend = PCSrcD | PCSrcE | PCSrcM;
  assign memStall = (state == IDLE & MemReqM & ~MemReadyM)
                  | (state == WAIT)
                  | (state == ERR);

  // a frozen pipeline must not lose instructions to a flush
  always_comb begin
    StallF = ldrStall | pcWrPend;
    StallD = ldrStall;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = pcWrPend | PCSrcW | BranchTakenE;
    FlushE = ldrStall | BranchTakenE;
    FlushW = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end
  end

  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    unique case (state)
      IDLE: begin
        if (MemReqM && !MemReadyM) begin
          nextState   = WAIT;
          waitCntNext = WCW'(1);
        end
      end
      WAIT: begin
        if (MemReadyM) begin
          nextState   = IDLE;
          waitCntNext = '0;
        end else if (waitCnt == WLAST) begin
          nextState = ERR;
        end else begin
          waitCntNext = waitCnt + WCW'(1);
        end
      end
      ERR: begin
        nextState = ERR;
      end
      default: begin
        nextState   = IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      waitCnt <= '0;
      MemErr  <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (nextState == ERR)
        MemErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      StallCycles <= '0;
      FlushCycles <= '0;
    end else begin
      if (StallF && StallCycles != '1)
        StallCycles <= StallCycles + CNT_W'(1);
      if (FlushE && FlushCycles != '1)
        FlushCycles <= FlushCycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed scenarios plus random stimulus
// compared every cycle against a behavioural model.
module tb_hazard_unit;

  localparam int MT = 4;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    Ra1D, Ra2D, Ra1E, Ra2E;
  logic [3:0]    WA3E, WA3M, WA3W;
  logic          RegWriteM, RegWriteW, MemtoRegE;
  logic          PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic          BranchTakenE, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW, MemErr;
  logic [CW-1:0] StallCycles, FlushCycles;

  hazard_unit #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Ra1D(Ra1D), .Ra2D(Ra2D), .Ra1E(Ra1E), .Ra2E(Ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemErr(MemErr),
    .StallCycles(StallCycles), .FlushCycles(FlushCycles)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nErr = 0;

  // model: outstanding wait, count of unready cycles, sticky error
  bit mWait, mErr;
  int mUnready, mStall, mFlush;

  logic [1:0] eFA, eFB;
  logic       eSF, eSD, eSE, eSM, eFD, eFE, eFW;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && ra == WA3M) return 2'b10;
    if (RegWriteW && ra == WA3W) return 2'b01;
    return 2'b00;
  endfunction

  task automatic computeExp();
    bit ldr, pend, ms;
    ldr  = MemtoRegE && (Ra1D == WA3E || Ra2D == WA3E);
    pend = PCSrcD || PCSrcE || PCSrcM;
    ms   = mErr || mWait || (MemReqM && !MemReadyM);
    eFA  = fwd(Ra1E);
    eFB  = fwd(Ra2E);
    if (ms) begin
      {eSF, eSD, eSE, eSM} = 4'b1111;
      {eFD, eFE, eFW} = 3'b001;
    end else begin
      eSF = ldr || pend;
      eSD = ldr;
      eSE = 1'b0;
      eSM = 1'b0;
      eFD = pend || PCSrcW || BranchTakenE;
      eFE = ldr || BranchTakenE;
      eFW = 1'b0;
    end
  endtask

  task automatic checkAll();
    computeExp();
    chk("fwdA", ForwardAE, eFA);
    chk("fwdB", ForwardBE, eFB);
    chk("stalls", {StallF, StallD, StallE, StallM},
        {eSF, eSD, eSE, eSM});
    chk("flushes", {FlushD, FlushE, FlushW}, {eFD, eFE, eFW});
    chk("memErr", MemErr, mErr);
    chk("stallCyc", StallCycles, mStall);
    chk("flushCyc", FlushCycles, mFlush);
  endtask

  task automatic modelEdge();
    computeExp();
    if (eSF) mStall = (mStall < SAT) ? mStall + 1 : SAT;
    if (eFE) mFlush = (mFlush < SAT) ? mFlush + 1 : SAT;
    if (mErr) begin
    end else if (mWait) begin
      if (MemReadyM) begin
        mWait = 0;
      end else begin
        mUnready++;
        if (mUnready >= MT) begin
          mErr  = 1;
          mWait = 0;
        end
      end
    end else if (MemReqM && !MemReadyM) begin
      mWait    = 1;
      mUnready = 1;
    end
  endtask

  task automatic modelReset();
    mWait = 0; mErr = 0; mUnready = 0;
    mStall = 0; mFlush = 0;
  endtask

  task automatic clearInputs();
    {Ra1D, Ra2D, Ra1E, Ra2E} = {4'd0, 4'd0, 4'd0, 4'd0};
    {WA3E, WA3M, WA3W} = {4'd1, 4'd2, 4'd3};
    {RegWriteM, RegWriteW, MemtoRegE} = 3'b000;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW} = 4'b0000;
    {BranchTakenE, MemReqM, MemReadyM} = 3'b000;
  endtask

  // caller has just driven inputs after a falling edge
  task automatic cycle();
    #1;
    checkAll();
    @(posedge clk);
    if (!reset) modelEdge();
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [3:0] rndReg();
    if ($urandom_range(0, 7) == 0) return 4'd15;
    return 4'($urandom_range(0, 3));
  endfunction

  initial begin
    clearInputs();
    modelReset();
    reset = 1'b1;
    #2;
    chk("rstMemErr", MemErr, 0);
    chk("rstStallCyc", StallCycles, 0);
    checkAll();
    @(negedge clk);
    reset = 1'b0;

    // forwarding priority
    {RegWriteM, RegWriteW} = 2'b11;
    {WA3M, WA3W, Ra1E} = {4'd3, 4'd3, 4'd3};
    #1 chk("fwdPrioM", ForwardAE, 2'b10);
    RegWriteM = 1'b0;
    #1 chk("fwdW", ForwardAE, 2'b01);
    Ra1E = 4'd15;
    #1 chk("fwdR15", ForwardAE, 2'b00);
    cycle();

    // load-use
    doReset();
    clearInputs();
    {MemtoRegE, WA3E, Ra2D} = {1'b1, 4'd5, 4'd5};
    #1 chk("ldUse", {StallF, StallD, FlushE, FlushD}, 4'b1110);
    cycle();
    chk("ldUseCnt", StallCycles, 1);
    clearInputs();
    cycle();

    // branch and PC writes in flight
    BranchTakenE = 1'b1;
    #1 chk("brTaken", {FlushD, FlushE, StallF}, 3'b110);
    cycle();
    clearInputs();
    PCSrcD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("pcPend", {StallF, FlushD}, 2'b11);
      cycle();
    end
    clearInputs();
    PCSrcW = 1'b1;
    #1 chk("pcW", {StallF, FlushD, FlushE}, 3'b010);
    cycle();

    // 3 unready cycles then ready: exactly MT-1 waits, no error
    clearInputs();
    {MemReqM, BranchTakenE} = 2'b11;
    for (int i = 0; i < 4; i++) begin
      MemReadyM = (i == 3);
      #1 chk("memWait",
             {StallF, StallD, StallE, StallM, FlushW, FlushE},
             6'b111110);
      cycle();
    end
    clearInputs();
    #1 chk("memDone", {StallF, StallE, FlushW, MemErr}, 4'b0000);
    cycle();

    // timeout into error, then asynchronous reset
    MemReqM = 1'b1;
    for (int i = 0; i < MT; i++) cycle();
    chk("toErr", MemErr, 1);
    MemReadyM = 1'b1;
    cycle();
    chk("errHold", {StallF, StallM, FlushW}, 3'b111);
    #3 reset = 1'b1;
    #1;
    modelReset();
    chk("errRst", {MemErr, StallF}, 2'b00);
    chk("errRstCnt", {StallCycles, FlushCycles}, 0);
    @(negedge clk);
    reset = 1'b0;

    // counter saturation
    clearInputs();
    {MemtoRegE, WA3E, Ra1D} = {1'b1, 4'd5, 4'd5};
    for (int i = 0; i < 20; i++) cycle();
    chk("satStall", StallCycles, SAT);
    chk("satFlush", FlushCycles, SAT);

    // random traffic against the model
    doReset();
    for (int n = 0; n < 3000; n++) begin
      Ra1D = rndReg(); Ra2D = rndReg();
      Ra1E = rndReg(); Ra2E = rndReg();
      WA3E = rndReg(); WA3M = rndReg(); WA3W = rndReg();
      RegWriteM    = ($urandom_range(0, 1) == 0);
      RegWriteW    = ($urandom_range(0, 1) == 0);
      MemtoRegE    = ($urandom_range(0, 3) == 0);
      PCSrcD       = ($urandom_range(0, 5) == 0);
      PCSrcE       = ($urandom_range(0, 5) == 0);
      PCSrcM       = ($urandom_range(0, 5) == 0);
      PCSrcW       = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemReqM      = ($urandom_range(0, 2) == 0);
      MemReadyM    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 49) == 0) doReset();
      else cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             nCmp, nErr);
    $finish;
  end

endmodule
